// File: rtl/demux_2out_16b.sv
// rtl/demux_2out_16b.sv - steers one source word to one of two buffered lanes with delivery counters

module demux_2out_16b_lane #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_fill,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_space,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

  lane_state_t      r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_drain;

  assign o_valid = (r_state == LANE_FULL);
  assign w_drain = o_valid & i_ready;
  // A draining lane can take a new word on the same edge.
  assign o_space = ~o_valid | i_ready;
  assign o_data  = r_data;
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LANE_EMPTY;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (i_fill) begin
        r_data <= i_data;
      end
      case (r_state)
        LANE_EMPTY: if (i_fill) r_state <= LANE_FULL;
        LANE_FULL:  if (w_drain && !i_fill) r_state <= LANE_EMPTY;
        default:    r_state <= LANE_EMPTY;
      endcase
    end
  end

endmodule

module demux_2out_16b #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] In,
  input  logic             S,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] OutA,
  output logic             ValidA,
  input  logic             ReadyA,
  output logic [WIDTH-1:0] OutB,
  output logic             ValidB,
  input  logic             ReadyB,
  output logic [CNT_W-1:0] CountA,
  output logic [CNT_W-1:0] CountB
);

  logic w_space_a;
  logic w_space_b;
  logic w_fill_a;
  logic w_fill_b;

  assign InReady  = S ? w_space_b : w_space_a;
  assign w_fill_a = InValid & InReady & ~S;
  assign w_fill_b = InValid & InReady &  S;

  demux_2out_16b_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane_a (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_fill  (w_fill_a),
    .i_data  (In),
    .i_ready (ReadyA),
    .o_data  (OutA),
    .o_valid (ValidA),
    .o_space (w_space_a),
    .o_count (CountA)
  );

  demux_2out_16b_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane_b (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_fill  (w_fill_b),
    .i_data  (In),
    .i_ready (ReadyB),
    .o_data  (OutB),
    .o_valid (ValidB),
    .o_space (w_space_b),
    .o_count (CountB)
  );

endmodule

// File: tb/tb_demux_2out_16b.sv
// tb/tb_demux_2out_16b.sv - scoreboard and vector-table bench for demux_2out_16b

module tb_demux_2out_16b;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] In = '0;
  logic        S = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [15:0] OutA;
  logic        ValidA;
  logic        ReadyA = 1'b0;
  logic [15:0] OutB;
  logic        ValidB;
  logic        ReadyB = 1'b0;
  logic [7:0]  CountA;
  logic [7:0]  CountB;

  int total = 0;
  int bad   = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  m_cnt_a = '0;
  logic [7:0]  m_cnt_b = '0;

  demux_2out_16b dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .In      (In),
    .S       (S),
    .InValid (InValid),
    .InReady (InReady),
    .OutA    (OutA),
    .ValidA  (ValidA),
    .ReadyA  (ReadyA),
    .OutB    (OutB),
    .ValidB  (ValidB),
    .ReadyB  (ReadyB),
    .CountA  (CountA),
    .CountB  (CountB)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    m_cnt_a = '0;
    m_cnt_b = '0;
  endtask

  // Scoreboard: inputs are stable at the falling edge, so handshakes seen here happen on the next rising edge.
  always @(negedge Clk) begin
    logic exp_rdy;
    logic [15:0] w;
    if (!Reset_n) begin
      clear_model();
    end else begin
      exp_rdy = S ? (qb.size() == 0 || ReadyB) : (qa.size() == 0 || ReadyA);
      chk("sb_in_ready", InReady, exp_rdy);
      chk("sb_valid_a", ValidA, qa.size() != 0);
      chk("sb_valid_b", ValidB, qb.size() != 0);
      chk("sb_count_a", CountA, m_cnt_a);
      chk("sb_count_b", CountB, m_cnt_b);
      if (qa.size() != 0 && ReadyA) begin
        w = qa.pop_front();
        chk("sb_out_a", OutA, w);
        m_cnt_a = m_cnt_a + 8'd1;
      end
      if (qb.size() != 0 && ReadyB) begin
        w = qb.pop_front();
        chk("sb_out_b", OutB, w);
        m_cnt_b = m_cnt_b + 8'd1;
      end
      if (InValid && exp_rdy) begin
        if (S) qb.push_back(In);
        else   qa.push_back(In);
      end
    end
  end

  task automatic drive(input logic s, input logic [15:0] d, input logic v,
                       input logic ra, input logic rb);
    @(posedge Clk);
    #1;
    S = s; In = d; InValid = v; ReadyA = ra; ReadyB = rb;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    S = 1'b0; In = '0; InValid = 1'b0; ReadyA = 1'b0; ReadyB = 1'b0;
    clear_model();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  typedef struct {
    logic        s;
    logic [15:0] d;
    logic        v;
    logic        ra;
    logic        rb;
    logic        rdy;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [7:0]  cnt_a;
    logic [7:0]  cnt_b;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //          s     d         v     ra    rb    rdy   out_a     out_b     cnt_a  cnt_b
    vecs[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 8'd0, 8'd0};
    vecs[1] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 8'd0, 8'd0};
    vecs[2] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 8'd0, 8'd0};
    vecs[3] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 8'd0, 8'd0};
    vecs[4] = '{1'b0, 16'hAAAA, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0002, 8'd0, 8'd1};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hAAAA, 16'h0002, 8'd0, 8'd1};
    vecs[6] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0002, 8'd1, 8'd1};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h0002, 8'd1, 8'd1};
    vecs[8] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h0002, 8'd1, 8'd1};
    vecs[9] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h0002, 8'd1, 8'd2};

    // Reset state and mid-stream asynchronous reset
    do_reset();
    #1;
    chk("rst_out_a", OutA, 16'h0);
    chk("rst_valid_a", ValidA, 1'b0);
    chk("rst_count_b", CountB, 8'd0);
    drive(1'b1, 16'h0011, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'h0012, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'h0013, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 16'h1234, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("mid_out_a", OutA, 16'h1234);
    chk("mid_valid_a", ValidA, 1'b1);
    chk("mid_count_b", CountB, 8'd3);
    #1 Reset_n = 1'b0;
    #1;
    chk("arst_out_a", OutA, 16'h0);
    chk("arst_valid_a", ValidA, 1'b0);
    chk("arst_count_b", CountB, 8'd0);
    chk("arst_out_b", OutB, 16'h0);
    clear_model();
    #1 Reset_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    #1 chk("post_rst_ready_s0", InReady, 1'b1);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    #1 chk("post_rst_ready_s1", InReady, 1'b1);

    // Basic steer to A
    do_reset();
    drive(1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("steer_valid_a", ValidA, 1'b1);
    chk("steer_out_a", OutA, 16'hBEEF);
    chk("steer_count_a0", CountA, 8'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("steer_valid_a_done", ValidA, 1'b0);
    chk("steer_count_a1", CountA, 8'd1);
    chk("steer_out_a_hold", OutA, 16'hBEEF);
    chk("steer_valid_b", ValidB, 1'b0);
    chk("steer_out_b", OutB, 16'h0);

    // Backpressure and lane independence from the vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].s, vecs[i].d, vecs[i].v, vecs[i].ra, vecs[i].rb);
      @(negedge Clk);
      chk($sformatf("vec%0d_in_ready", i), InReady, vecs[i].rdy);
      chk($sformatf("vec%0d_out_a", i), OutA, vecs[i].out_a);
      chk($sformatf("vec%0d_out_b", i), OutB, vecs[i].out_b);
      chk($sformatf("vec%0d_count_a", i), CountA, vecs[i].cnt_a);
      chk($sformatf("vec%0d_count_b", i), CountB, vecs[i].cnt_b);
    end

    // Full throughput, alternating lanes
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 16'(i), 1'b1, 1'b1, 1'b1);
      #1 chk($sformatf("tput_ready%0d", i), InReady, 1'b1);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("tput_count_a", CountA, 8'd5);
    chk("tput_count_b", CountB, 8'd5);
    chk("tput_out_b_last", OutB, 16'h0009);

    // Counter wrap on lane A
    do_reset();
    for (int i = 0; i < 257; i++) begin
      drive(1'b0, 16'(i + 16'h100), 1'b1, 1'b1, 1'b0);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("wrap_count_a", CountA, 8'd1);
    chk("wrap_count_b", CountB, 8'd0);
    chk("wrap_valid_a", ValidA, 1'b0);

    @(negedge Clk);
    chk("sb_drained_a", qa.size(), 0);
    chk("sb_drained_b", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_2out_16b.md
Name: demux_2out_16b

Overview:
- Destination side of the 2-input 16-bit bus select path: one 16-bit source word is steered to one of two registered 16-bit destinations (A or B) under select S.
- Each destination holds its word in a one-entry buffer with a valid/ready handshake, so a slow consumer stalls only its own lane.
- Per-destination 8-bit delivery counters support bring-up and debug.

Parameters:
- WIDTH, 16, data width of the input bus and each destination.
- CNT_W, 8, width of each delivery counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- In  input  WIDTH  source word.
- S  input  1  destination select: 0 steers to A, 1 steers to B. Sampled with In.
- InValid  input  1  source presents a word on In/S.
- InReady  output  1  block accepts the word this cycle (combinational).
- OutA  output  WIDTH  lane A held word.
- ValidA  output  1  OutA holds an undelivered word.
- ReadyA  input  1  lane A consumer accepts OutA.
- OutB  output  WIDTH  lane B held word.
- ValidB  output  1  OutB holds an undelivered word.
- ReadyB  input  1  lane B consumer accepts OutB.
- CountA  output  CNT_W  words delivered on lane A.
- CountB  output  CNT_W  words delivered on lane B.

Behaviour:
- Reset (Reset_n low, any time, asynchronous): OutA=OutB=0, ValidA=ValidB=0, CountA=CountB=0. Any word in flight is discarded. First capture is possible on the first rising edge after Reset_n goes high.
- Lane state machine, per lane X in {A,B}, two states:
  - EMPTY (ValidX=0) -> FULL on a fill.
  - FULL (ValidX=1) -> EMPTY on a drain without a fill.
  - FULL -> FULL on a drain with a simultaneous fill, or on no event.
- Drain: ValidX && ReadyX at a rising edge. CountX increments by 1, modulo 2^CNT_W (255 -> 0, no saturation, no flag).
- Fill: InValid && InReady with S selecting X at a rising edge. OutX <= In and ValidX <= 1.
- InReady is combinational: when S=0, InReady = ~ValidA | ReadyA; when S=1, InReady = ~ValidB | ReadyB. No dependence on InValid. A full, drained lane accepts a new word in the same cycle, giving full throughput.
- Latency: a word accepted at edge N appears on OutX with ValidX=1 after edge N, and is deliverable at edge N+1.
- The unselected lane is never written. OutX holds its value while FULL and not draining, and holds the last value after draining (contents are don't-care when ValidX=0, but must not change).
- The source may change S only when no transfer is pending. With InValid=1 and InReady=0, S and In are held by the source; behaviour is undefined if they change.
- Both lanes may drain in the same cycle. A fill of one lane and a drain of the other may occur in the same cycle. All are independent.
- ReadyX while ValidX=0: ignored; no count.
- No combinational path from In to OutA/OutB.

Test Plan:
- Reset mid-stream: load A with 0x1234 (ValidA=1), CountB=3, then pulse Reset_n low between edges -> immediately OutA=0, ValidA=0, CountB=0. After release, InReady=1 for S=0 and S=1.
- Basic steer: S=0, In=0xBEEF, InValid=1 for one cycle, ReadyA=1 -> ValidA=1, OutA=0xBEEF for one cycle, then CountA=1. ValidB stays 0 and OutB stays 0.
- Backpressure: ReadyB=0, send 0x0001 to B, then present 0x0002 to B -> InReady=0 and OutB holds 0x0001. Raise ReadyB -> same edge drains 0x0001 and loads 0x0002, ValidB stays 1, CountB=1.
- Lane independence: lane B full and stalled (ReadyB=0), send 0xAAAA with S=0 and ReadyA=1 -> accepted, delivered on A, CountA=1. OutB and ValidB unchanged.
- Throughput: 10 consecutive words 0x0000..0x0009 alternating S=0/1, both Ready=1 -> InReady=1 every cycle. Lane A delivers even values in order and lane B odd values. CountA=CountB=5.
- Counter wrap: 257 words to A with ReadyA=1 -> CountA=1 (wrapped through 0). CountB=0.
